// File: rtl/x7seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
//   SEG_TABLE : hex nibble -> active-low segments {a,b,c,d,e,f,g}
//   SEG_OFF   : all segments dark
//   BRIGHT_W  : width of the brightness phase taken from the prescaler MSBs
package x7seg_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned BRIGHT_W = 3;

  localparam seg_t SEG_OFF = 7'b1111111;

  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/x7seg_if.sv
// Display bus between a host and the scanner.
//   host -> scanner : data (nibble per digit), dp, blank, load strobe, lzb, bright
//   scanner -> pins : a_to_g, dp_n, an (all active-low), frame pulse
interface x7seg_if #(
  parameter int unsigned NDIG = 4
);
  import x7seg_pkg::*;

  logic [4*NDIG-1:0]   data;
  logic [NDIG-1:0]     dp;
  logic [NDIG-1:0]     blank;
  logic                load;
  logic                lzb;
  logic [BRIGHT_W-1:0] bright;

  logic [6:0]          a_to_g;
  logic                dp_n;
  logic [NDIG-1:0]     an;
  logic                frame;

  modport master (
    output data, dp, blank, load, lzb, bright,
    input  a_to_g, dp_n, an, frame
  );

  modport slave (
    input  data, dp, blank, load, lzb, bright,
    output a_to_g, dp_n, an, frame
  );

endinterface

// File: rtl/x7seg_dec.sv
// Combinational hex-to-7-segment decoder.
//   nib_i : hex nibble
//   seg_o : active-low segments, bit6 = a .. bit0 = g
module x7seg_dec
  import x7seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/x7seg_scan.sv
// Time-multiplexed 7-segment display scanner with double-buffered digit data,
// leading-zero blanking, per-digit blanking and PWM brightness.
//   clk, rst : clock, synchronous active-high reset
//   bus      : x7seg_if slave (host inputs in, registered display pins out)
module x7seg_scan
  import x7seg_pkg::*;
#(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned PRESC = 15
) (
  input logic    clk,
  input logic    rst,
  x7seg_if.slave bus
);

  localparam int unsigned SW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [SW-1:0] LAST = SW'(NDIG - 1);

  logic [PRESC-1:0]  presc_q, presc_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic              pend_q, pend_d;
  logic [4*NDIG-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [NDIG-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NDIG-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;

  seg_t              seg_q, seg_d;
  logic              dpn_q, dpn_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              frame_q, frame_d;

  logic              tick, boundary;
  logic [BRIGHT_W-1:0] phase;
  logic [3:0]        nib;
  logic              dp_s, blank_s, lz_s, lz_run;
  seg_t              dec_seg;

  assign tick     = &presc_q;
  assign boundary = tick && (slot_q == LAST);
  assign phase    = presc_q[PRESC-1 -: BRIGHT_W];

  // Scan counters and the pending/active double buffer.
  always_comb begin
    presc_d      = presc_q + PRESC'(1);
    slot_d       = slot_q;
    pend_d       = pend_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;

    if (tick) begin
      slot_d = (slot_q == LAST) ? '0 : slot_q + SW'(1);
    end

    if (boundary && pend_q) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
      pend_d      = 1'b0;
    end

    // A load on the boundary cycle lands after the transfer, so it waits a frame.
    if (bus.load) begin
      pend_data_d  = bus.data;
      pend_dp_d    = bus.dp;
      pend_blank_d = bus.blank;
      pend_d       = 1'b1;
    end
  end

  // Select the current slot; lz_run tracks "all digits from the top down to i are zero".
  always_comb begin
    nib     = 4'h0;
    dp_s    = 1'b0;
    blank_s = 1'b0;
    lz_s    = 1'b0;
    lz_run  = 1'b1;
    an_d    = '1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      lz_run = lz_run && (act_data_q[4*i +: 4] == 4'h0);
      if (slot_q == SW'(i)) begin
        nib     = act_data_q[4*i +: 4];
        dp_s    = act_dp_q[i];
        blank_s = act_blank_q[i];
        lz_s    = lz_run && (i != 0);
        if (phase <= bus.bright) an_d[i] = 1'b0;
      end
    end
  end

  x7seg_dec u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    seg_d   = (blank_s || (bus.lzb && lz_s)) ? SEG_OFF : dec_seg;
    dpn_d   = blank_s ? 1'b1 : ~dp_s;
    frame_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      slot_q       <= '0;
      pend_q       <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      seg_q        <= SEG_OFF;
      dpn_q        <= 1'b1;
      an_q         <= '1;
      frame_q      <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      slot_q       <= slot_d;
      pend_q       <= pend_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      seg_q        <= seg_d;
      dpn_q        <= dpn_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign bus.a_to_g = seg_q;
  assign bus.dp_n   = dpn_q;
  assign bus.an     = an_q;
  assign bus.frame  = frame_q;

endmodule

// File: doc/x7seg_scan.md
X7SEG_SCAN -- requirements
Module: x7seg_scan

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter PRESC, default 15: per-digit dwell of 2^PRESC clocks, legal range 3..24.
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port data  in  4*NDIG  hex nibble per digit, digit i = data[4i+3:4i], digit 0 rightmost.
REQ-006 SHALL have port dp  in  NDIG  decimal point per digit, 1 = lit.
REQ-007 SHALL have port blank  in  NDIG  per-digit blank mask, 1 = segments and dp off.
REQ-008 SHALL have port load  in  1  one-cycle strobe capturing data/dp/blank into the pending register.
REQ-009 SHALL have port lzb  in  1  leading-zero blanking enable, level.
REQ-010 SHALL have port bright  in  3  brightness 0 (dimmest) .. 7 (full).
REQ-011 SHALL have port a_to_g  out  7  segments, active-low, bit6 = a .. bit0 = g.
REQ-012 SHALL have port dp_n  out  1  decimal point, active-low.
REQ-013 SHALL have port an  out  NDIG  digit anodes, active-low, at most one low.
REQ-014 SHALL have port frame  out  1  one-cycle pulse at each frame boundary.

Function
REQ-015 SHALL run a free PRESC-bit prescaler, incrementing every clock and wrapping; tick = prescaler all-ones.
REQ-016 SHALL hold slot index s, advancing on tick, wrapping NDIG-1 -> 0; frame boundary = tick with s = NDIG-1.
REQ-017 SHALL pulse frame for exactly the boundary cycle; with NDIG=1, every tick is a boundary.
REQ-018 SHALL capture data/dp/blank on load and set a pending flag; a later load before the boundary overwrites the pending values.
REQ-019 SHALL copy pending to active and clear the flag at a frame boundary when the flag is set; active SHALL never change mid-frame.
REQ-020 When load and a boundary coincide, SHALL transfer the previously pending values and hold the new capture pending for the next boundary.
REQ-021 SHALL decode the active nibble of slot s: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-022 With lzb=1, SHALL force a_to_g=1111111 on digit i>0 when active digits NDIG-1..i are all zero; digit 0 is never leading-zero blanked; dp unaffected.
REQ-023 SHALL force a_to_g=1111111 and dp_n=1 on any digit whose active blank bit is 1.
REQ-024 SHALL drive an[s] low only while prescaler[PRESC-1:PRESC-3] <= bright, else all an high (bright=7 -> 100% duty, 0 -> 1/8).
REQ-025 SHALL register a_to_g, dp_n, an and frame: one-cycle latency from prescaler/s state to pins.

Reset
REQ-026 On rst, SHALL clear prescaler, s, pending flag, and pending/active data, dp and blank to 0.
REQ-027 In the cycle after rst is sampled high, SHALL present an = all ones, a_to_g = 1111111, dp_n = 1, frame = 0.
REQ-028 Reset asserted mid-frame SHALL discard pending data and restart at slot 0 with prescaler 0.

Structure
REQ-029 SHALL place the 16-entry segment table, the SEG_OFF constant (7'b1111111) and the brightness phase width (3) in shared package x7seg_pkg.
REQ-030 SHALL implement decoding in combinational sub-module x7seg_dec (4-bit in, 7-bit active-low out); all counters and registers stay in x7seg_scan.

Verification (NDIG=4, PRESC=4 unless stated)
REQ-031 SHALL test: reset, load data=16'h1234, bright=7 -> after the first frame pulse, slot 0 shows an=1110 a_to_g=1001100, slot 3 shows an=0111 a_to_g=1001111, each for 16 cycles.
REQ-032 SHALL test: load 16'hABCD mid-frame -> old digits persist until frame pulse; next frame slot 0 a_to_g=1000010 (d).
REQ-033 SHALL test: data=16'h0070, lzb=1 -> slots 3,2 a_to_g=1111111; slot 1 0001111; slot 0 0000001.
REQ-034 SHALL test: bright=0 -> an low for exactly 2 of each 16-cycle slot; bright=3 -> 8 of 16.
REQ-035 SHALL test: rst pulsed at s=2 -> next cycle an=1111, a_to_g=1111111; display resumes at slot 0 showing 0; prior pending load lost.
REQ-036 SHALL test: NDIG=1 -> an[0] only, frame pulses every 16 cycles, load + boundary coincidence per REQ-020.
